pool_serializer: RTL

POOL_SERIALIZER -- requirements
Module: pool_serializer

---
 rtl/pool_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pool_serializer.sv
// pool_serializer: captures a flattened pooled feature vector on start and
// streams it out one DW-bit feature per handshake, channel-major order.
//
// Output handshake: out_vld/out_data/out_idx/out_last come from registered
// state only. A feature transfers on a rising edge where out_vld=1 and
// out_rdy=1. While out_vld=1 and out_rdy=0 the payload holds stable, and
// out_vld never drops before its transfer. out_rdy is ignored while out_vld=0.
module pool_serializer #(
    parameter int DW   = 8,
    parameter int NCH  = 3,
    parameter int NPOS = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NCH*NPOS*DW-1:0]   pool_lin,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [DW-1:0]            out_data,
    output logic [4:0]               out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic [1:0]               state_dbg
);

    localparam int NTOT = NCH * NPOS;
    localparam logic [4:0] LAST_K = 5'(NTOT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [4:0]             k, k_nxt;
    logic [NTOT*DW-1:0]     shadow;
    logic                   latch;
    logic                   ovf_q, ovf_nxt;

    // State register; reset wins over any start or handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: feature index, shadow copy of the vector, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            shadow <= '0;
            ovf_q  <= 1'b0;
        end else begin
            k     <= k_nxt;
            ovf_q <= ovf_nxt;
            if (latch) begin
                shadow <= pool_lin;
            end
        end
    end

    // Next-state logic: accept start in IDLE or DONE, advance k on each handshake.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        latch     = 1'b0;
        ovf_nxt   = ovf_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_STREAM;
                    k_nxt     = '0;
                    latch     = 1'b1;
                end
            end
            S_STREAM: begin
                // A start here is dropped; only the sticky flag records it.
                if (start) begin
                    ovf_nxt = 1'b1;
                end
                if (out_rdy) begin
                    if (k == LAST_K) begin
                        state_nxt = S_DONE;
                        k_nxt     = '0;
                    end else begin
                        k_nxt = k + 5'd1;
                    end
                end
            end
            S_DONE: begin
                // Back-to-back vectors: start here re-latches with a one-cycle gap.
                if (start) begin
                    state_nxt = S_STREAM;
                    k_nxt     = '0;
                    latch     = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                k_nxt     = '0;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        out_vld   = (state == S_STREAM);
        busy      = (state == S_STREAM);
        done      = (state == S_DONE);
        out_idx   = k;
        out_last  = (state == S_STREAM) && (k == LAST_K);
        out_data  = '0;
        if (state == S_STREAM) begin
            out_data = shadow[DW*int'(k) +: DW];
        end
        ovf       = ovf_q;
        state_dbg = state;
    end

endmodule
